// File: rtl/nn_pkg.sv
// +---------------------------------------------------------------+
// | nn_pkg : shared constants, types and helpers for the          |
// |          neural_classifier perceptron front end.              |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

package nn_pkg;
   localparam int               N_IN_DEF   = 256;
   localparam logic signed [7:0] LR_DEF    = 8'sd4;
   localparam int               INK_TH_DEF = 1536;
   localparam int               GRID       = 16;
   localparam int               WIN        = 256;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } stream_st_e;

   // |z| clamped to 12 bits; the 33-bit intermediate keeps -2^31 positive.
   function automatic logic [11:0] abs_sat12(input logic signed [31:0] z);
      logic [32:0] mag;
      mag = z[31] ? (33'd0 - {1'b1, z}) : {1'b0, z};
      return (|mag[32:12]) ? 12'hFFF : mag[11:0];
   endfunction
endpackage

`default_nettype wire

// File: rtl/neural_classifier_if.sv
// +---------------------------------------------------------------+
// | neural_classifier_if : pixel, command and result bundle.      |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

interface neural_classifier_if;
   logic [9:0]        Draw_X, Draw_Y;
   logic [9:0]        oVGA_R, oVGA_G, oVGA_B;
   logic              label;
   logic signed [31:0] Z;
   logic              classify, Record_X, Up_W;
   logic [9:0]        VGA_Red, VGA_Green, VGA_Blue;
   logic              x_values, Get, Get_done, RstH, Hw;
   logic signed [7:0] delta_w;
   logic              delta_valid;
   logic [7:0]        delta_idx;
   logic [15:0]       To_Hex;

   modport master (
      output Draw_X, Draw_Y, oVGA_R, oVGA_G, oVGA_B, label, Z, classify, Record_X, Up_W,
      input  VGA_Red, VGA_Green, VGA_Blue, x_values, Get, Get_done, RstH, Hw,
             delta_w, delta_valid, delta_idx, To_Hex
   );
   modport slave (
      input  Draw_X, Draw_Y, oVGA_R, oVGA_G, oVGA_B, label, Z, classify, Record_X, Up_W,
      output VGA_Red, VGA_Green, VGA_Blue, x_values, Get, Get_done, RstH, Hw,
             delta_w, delta_valid, delta_idx, To_Hex
   );
endinterface

`default_nettype wire

// File: rtl/delta_w_gen.sv
// +---------------------------------------------------------------+
// | delta_w_gen : recorded-input register and per-index weight    |
// |               delta streamer.  Rev 1.0                        |
// +---------------------------------------------------------------+
`default_nettype none

module delta_w_gen
   import nn_pkg::*;
#(
   parameter int               N_IN = N_IN_DEF,
   parameter logic signed [7:0] LR  = LR_DEF
) (
   input  logic              Clk,
   input  logic              RST,
   input  logic              store_i,
   input  logic              bit_i,
   input  logic [7:0]        bit_idx_i,
   input  logic              up_w_i,
   input  logic              label_i,
   input  logic              hw_i,
   output logic signed [7:0] delta_w_o,
   output logic              delta_valid_o,
   output logic [7:0]        delta_idx_o
);
   stream_st_e      state_q, state_d;
   logic [7:0]      idx_q, idx_d;
   logic [N_IN-1:0] x_q, snap_q, snap_d;
   logic            err_q, err_d, pos_q, pos_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      err_d   = err_q;
      pos_d   = pos_q;
      case (state_q)
         ST_IDLE: begin
            if (up_w_i) begin
               state_d = ST_STREAM;
               idx_d   = '0;
               snap_d  = x_q;
               err_d   = (label_i != hw_i);
               pos_d   = label_i;
            end
         end
         ST_STREAM: begin
            if (idx_q == 8'(N_IN - 1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         snap_q  <= '0;
         err_q   <= 1'b0;
         pos_q   <= 1'b0;
         x_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         err_q   <= err_d;
         pos_q   <= pos_d;
         if (store_i) x_q[bit_idx_i] <= bit_i;
      end
   end

   assign delta_valid_o = (state_q == ST_STREAM);
   assign delta_idx_o   = idx_q;
   assign delta_w_o     = (delta_valid_o && err_q && snap_q[idx_q]) ? (pos_q ? LR : -LR) : 8'sd0;
endmodule

`default_nettype wire

// File: rtl/neural_classifier.sv
// +---------------------------------------------------------------+
// | neural_classifier : camera sampler, grid overlay display and  |
// |                     perceptron decision / update front end.   |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module neural_classifier
   import nn_pkg::*;
#(
   parameter int               N_IN   = N_IN_DEF,
   parameter logic signed [7:0] LR    = LR_DEF,
   parameter int               INK_TH = INK_TH_DEF
) (
   input  logic             Clk,
   input  logic             RST,
   neural_classifier_if.slave bus
);
   localparam int         GB    = $clog2(GRID);
   localparam int         WB    = $clog2(WIN);
   localparam logic [9:0] WIN_C = 10'(WIN);

   logic        w_blank, w_in_win, w_grid, w_samp, w_rsth, w_ink, w_get;
   logic [11:0] w_sum;
   logic [7:0]  w_idx;

   logic [9:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        xv_q, xv_d, get_q, get_d, done_q, done_d, rsth_q, rsth_d;
   logic        hw_q, hw_d, rec_q, rec_d, arm_q, arm_d;
   logic [15:0] hex_q, hex_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [7:0]  idx_q, idx_d;

   logic signed [7:0] w_dw;
   logic              w_dv;
   logic [7:0]        w_di;

   assign w_blank  = (bus.Draw_X >= 10'd640) || (bus.Draw_Y >= 10'd480);
   assign w_in_win = (bus.Draw_X < WIN_C) && (bus.Draw_Y < WIN_C);
   assign w_grid   = (bus.Draw_X[GB-1:0] == '0) || (bus.Draw_Y[GB-1:0] == '0);
   assign w_samp   = w_in_win && (bus.Draw_X[GB-1:0] == '0) && (bus.Draw_Y[GB-1:0] == '0);
   assign w_rsth   = (bus.Draw_X == 10'd0) && (bus.Draw_Y == 10'd480);
   assign w_sum    = {2'b00, bus.oVGA_R} + {2'b00, bus.oVGA_G} + {2'b00, bus.oVGA_B};
   assign w_ink    = (w_sum < 12'(INK_TH));
   assign w_idx    = {bus.Draw_Y[WB-1:GB], bus.Draw_X[WB-1:GB]};
   // Sampling stays off after reset until the first end-of-frame marker.
   assign w_get    = w_samp && arm_q && (cnt_q < 9'(N_IN)) && !w_rsth;

   always_comb begin
      r_d    = bus.oVGA_R;
      g_d    = bus.oVGA_G;
      b_d    = bus.oVGA_B;
      xv_d   = xv_q;
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      rec_d  = rec_q;
      arm_d  = arm_q;
      hw_d   = hw_q;
      hex_d  = hex_q;
      get_d  = w_get;
      done_d = get_q && (cnt_q == 9'(N_IN));
      rsth_d = w_rsth;

      if (w_blank) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end else if (w_in_win && w_grid) begin
         r_d = 10'h3FF;
         g_d = 10'h3FF;
         b_d = 10'h3FF;
      end else if (w_in_win && w_ink) begin
         r_d = '0;
         g_d = '0;
         b_d = '0;
      end

      if (w_samp) begin
         xv_d  = w_ink;
         idx_d = w_idx;
      end

      if (w_rsth) begin
         cnt_d = '0;
         rec_d = 1'b0;
         arm_d = 1'b1;
      end else begin
         if (w_get)        cnt_d = cnt_q + 9'd1;
         if (bus.Record_X) rec_d = 1'b1;
      end

      if (bus.classify) begin
         hw_d  = (bus.Z > 32'sd0);
         hex_d = {3'b000, hw_d, abs_sat12(bus.Z)};
      end
   end

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
         xv_q   <= 1'b0;
         get_q  <= 1'b0;
         done_q <= 1'b0;
         rsth_q <= 1'b0;
         hw_q   <= 1'b0;
         hex_q  <= '0;
         cnt_q  <= '0;
         idx_q  <= '0;
         rec_q  <= 1'b0;
         arm_q  <= 1'b0;
      end else begin
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
         xv_q   <= xv_d;
         get_q  <= get_d;
         done_q <= done_d;
         rsth_q <= rsth_d;
         hw_q   <= hw_d;
         hex_q  <= hex_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         rec_q  <= rec_d;
         arm_q  <= arm_d;
      end
   end

   delta_w_gen #(
      .N_IN (N_IN),
      .LR   (LR)
   ) u_delta_w_gen (
      .Clk           (Clk),
      .RST           (RST),
      .store_i       (get_q && rec_q),
      .bit_i         (xv_q),
      .bit_idx_i     (idx_q),
      .up_w_i        (bus.Up_W),
      .label_i       (bus.label),
      .hw_i          (hw_q),
      .delta_w_o     (w_dw),
      .delta_valid_o (w_dv),
      .delta_idx_o   (w_di)
   );

   assign bus.VGA_Red     = r_q;
   assign bus.VGA_Green   = g_q;
   assign bus.VGA_Blue    = b_q;
   assign bus.x_values    = xv_q;
   assign bus.Get         = get_q;
   assign bus.Get_done    = done_q;
   assign bus.RstH        = rsth_q;
   assign bus.Hw          = hw_q;
   assign bus.To_Hex      = hex_q;
   assign bus.delta_w     = w_dw;
   assign bus.delta_valid = w_dv;
   assign bus.delta_idx   = w_di;
endmodule

`default_nettype wire

// File: tb/tb_neural_classifier.sv
// +---------------------------------------------------------------+
// | tb_neural_classifier : self-checking bench for the classifier |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module tb_neural_classifier;
   logic Clk = 1'b0;
   logic RST = 1'b0;
   always #5 Clk = ~Clk;

   neural_classifier_if bus();

   neural_classifier #(
      .N_IN   (256),
      .LR     (8'sd4),
      .INK_TH (1536)
   ) dut (
      .Clk (Clk),
      .RST (RST),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;
   int n_get = 0, n_done = 0, n_dv = 0, n_pos = 0, n_neg = 0;

   // Reference model state: frame-level view of the classifier.
   typedef struct packed {
      logic [7:0]        idx;
      logic signed [7:0] dw;
   } dl_t;
   dl_t               sq[$];
   bit                img[256];
   int                m_cnt;
   bit                m_arm, m_rec;
   logic [7:0]        m_idx;
   logic [9:0]        e_r, e_g, e_b;
   logic              e_xv, e_get, e_done, e_rsth, e_hw, e_dv;
   logic [15:0]       e_hex;
   logic [7:0]        e_di;
   logic signed [7:0] e_dw;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int x, y, s;
      bit samp, rpt, ink, busy;
      longint mag;
      dl_t d;
      if (RST !== 1'b1) begin
         {e_r, e_g, e_b} = '0;
         {e_xv, e_get, e_done, e_rsth, e_hw, e_dv} = '0;
         e_hex = '0; e_di = '0; e_dw = '0;
         sq.delete();
         foreach (img[i]) img[i] = 1'b0;
         m_cnt = 0; m_arm = 0; m_rec = 0; m_idx = '0;
         return;
      end
      x = int'(bus.Draw_X);
      y = int'(bus.Draw_Y);
      s = int'(bus.oVGA_R) + int'(bus.oVGA_G) + int'(bus.oVGA_B);
      ink = (s < 1536);
      if (x >= 640 || y >= 480) {e_r, e_g, e_b} = '0;
      else if (x < 256 && y < 256 && (x % 16 == 0 || y % 16 == 0)) {e_r, e_g, e_b} = {3{10'h3FF}};
      else if (x < 256 && y < 256 && ink) {e_r, e_g, e_b} = '0;
      else {e_r, e_g, e_b} = {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B};
      // stream: a new request is honoured only when nothing is being shown
      busy = e_dv;
      if (sq.size() > 0) begin
         d = sq.pop_front(); e_dv = 1; e_di = d.idx; e_dw = d.dw;
      end else begin
         e_dv = 0; e_di = '0; e_dw = '0;
      end
      if (bus.Up_W && !busy) begin
         for (int i = 0; i < 256; i++) begin
            d.idx = 8'(i);
            d.dw  = (bus.label != e_hw && img[i]) ? (bus.label ? 8'sd4 : -8'sd4) : 8'sd0;
            sq.push_back(d);
         end
         d = sq.pop_front(); e_dv = 1; e_di = d.idx; e_dw = d.dw;
      end
      if (e_get && m_rec) img[m_idx] = e_xv;
      e_done = e_get && (m_cnt == 256);
      samp = (x < 256 && y < 256 && x % 16 == 0 && y % 16 == 0);
      rpt  = (x == 0 && y == 480);
      if (samp) begin
         e_xv  = ink;
         m_idx = 8'((y / 16) * 16 + x / 16);
      end
      e_get  = samp && m_arm && (m_cnt < 256) && !rpt;
      if (e_get) m_cnt++;
      e_rsth = rpt;
      if (rpt) begin
         m_cnt = 0; m_rec = 0; m_arm = 1;
      end else if (bus.Record_X) m_rec = 1;
      if (bus.classify) begin
         mag = longint'(bus.Z);
         if (mag < 0) mag = -mag;
         e_hw  = (bus.Z > 0);
         e_hex = {3'b000, e_hw, (mag > 4095) ? 12'hFFF : 12'(mag)};
      end
   endtask

   task automatic tick(input int x, input int y, input bit c, input bit r, input bit u);
      @(negedge Clk);
      bus.Draw_X = 10'(x); bus.Draw_Y = 10'(y);
      bus.classify = c; bus.Record_X = r; bus.Up_W = u;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(700, 10, 0, 0, 0);
   endtask

   task automatic set_rgb(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
      bus.oVGA_R = r; bus.oVGA_G = g; bus.oVGA_B = b;
   endtask

   function automatic logic [9:0] colour(input int mode, input int i, input int j);
      if (mode == 0) return 10'd210;
      if (mode == 1) return 10'd600;
      return ((i + j) % 3 == 0) ? 10'd100 : 10'd600;
   endfunction

   task automatic scan(input int mode);
      logic [9:0] c;
      for (int j = 0; j < 16; j++)
         for (int i = 0; i < 16; i++) begin
            c = colour(mode, i, j);
            set_rgb(c, c, c);
            tick(i * 16, j * 16, 0, 0, 0);
            tick(i * 16 + 5, j * 16 + 3, 0, 0, 0);
         end
      idle(4);
   endtask

   task automatic classify_z(input logic signed [31:0] z);
      bus.Z = z;
      tick(700, 10, 1, 0, 0);
      tick(700, 10, 0, 0, 0);
   endtask

   logic signed [31:0] zt[8] = '{32'sd5, -32'sd5000, 32'sd0, 32'sh8000_0000,
                                  32'sd4095, 32'sd4096, 32'sh7FFF_FFFF, 32'sd1};
   logic [15:0]        ht[8] = '{16'h1005, 16'h0FFF, 16'h0000, 16'h0FFF,
                                  16'h1FFF, 16'h1FFF, 16'h1FFF, 16'h1001};

   initial begin
      bus.Draw_X = 10'd700; bus.Draw_Y = 10'd10;
      set_rgb(0, 0, 0);
      bus.label = 0; bus.Z = '0;
      bus.classify = 0; bus.Record_X = 0; bus.Up_W = 0;
      fork
         forever begin
            @(posedge Clk or negedge RST);
            model_step();
         end
         forever begin
            @(negedge Clk);
            if (cmp_en) begin
               chk("vga_r", bus.VGA_Red, e_r);
               chk("vga_g", bus.VGA_Green, e_g);
               chk("vga_b", bus.VGA_Blue, e_b);
               chk("x_values", bus.x_values, e_xv);
               chk("get", bus.Get, e_get);
               chk("get_done", bus.Get_done, e_done);
               chk("rsth", bus.RstH, e_rsth);
               chk("hw", bus.Hw, e_hw);
               chk("to_hex", bus.To_Hex, e_hex);
               chk("delta_valid", bus.delta_valid, e_dv);
               chk("delta_idx", bus.delta_idx, e_di);
               chk("delta_w", bus.delta_w, e_dw);
            end
            if (bus.Get === 1'b1)       n_get++;
            if (bus.Get_done === 1'b1)  n_done++;
            if (bus.delta_valid === 1'b1) n_dv++;
            if (bus.delta_w === 8'sd4)  n_pos++;
            if (bus.delta_w === -8'sd4) n_neg++;
         end
         begin
            #1_000_000;
            chk("watchdog_timeout", 0, 1);
         end
         begin : main
            int g0, d0, v0, p0, q0;
            bit found;
            repeat (3) @(negedge Clk);
            chk("rst_vga_r", bus.VGA_Red, 0);
            chk("rst_get", bus.Get, 0);
            chk("rst_hw", bus.Hw, 0);
            chk("rst_hex", bus.To_Hex, 0);
            chk("rst_dvalid", bus.delta_valid, 0);
            chk("rst_didx", bus.delta_idx, 0);
            cmp_en = 1'b1;
            RST    = 1'b1;
            idle(2);

            for (int k = 0; k < 8; k++) begin
               classify_z(zt[k]);
               chk("cls_hw", bus.Hw, ht[k][12]);
               chk("cls_hex", bus.To_Hex, ht[k]);
            end
            idle(3);
            chk("hold_hex", bus.To_Hex, 16'h1001);

            set_rgb(512, 512, 512); tick(5, 5, 0, 0, 0);    idle(1);
            chk("th_1536_not_ink", bus.VGA_Red, 512);
            set_rgb(511, 512, 512); tick(5, 5, 0, 0, 0);    idle(1);
            chk("th_1535_ink", bus.VGA_Green, 0);
            tick(16, 5, 0, 0, 0);   idle(1);
            chk("grid_px", bus.VGA_Blue, 10'h3FF);
            tick(300, 5, 0, 0, 0);  idle(1);
            chk("outside_pass", bus.VGA_Red, 511);
            tick(640, 5, 0, 0, 0);  idle(1);
            chk("blank_x640", bus.VGA_Red, 0);

            g0 = n_get; d0 = n_done;
            tick(0, 480, 0, 0, 0); tick(700, 10, 0, 1, 0);
            scan(0);
            chk("scan210_gets", n_get - g0, 256);
            chk("scan210_done", n_done - d0, 1);
            g0 = n_get;
            tick(0, 0, 0, 0, 0); idle(3);
            chk("get_suppressed", n_get - g0, 0);

            classify_z(-32'sd5);
            bus.label = 1;
            v0 = n_dv; p0 = n_pos;
            tick(700, 10, 0, 0, 1); idle(1);
            chk("stream_start_idx", bus.delta_idx, 0);
            chk("stream_start_valid", bus.delta_valid, 1);
            idle(8); tick(700, 10, 0, 1, 1);
            idle(260);
            chk("stream_pos_cnt", n_pos - p0, 256);
            chk("stream_len", n_dv - v0, 256);

            bus.label = 0;
            v0 = n_dv; p0 = n_pos; q0 = n_neg;
            tick(700, 10, 0, 0, 1); idle(260);
            chk("agree_nonzero", (n_pos - p0) + (n_neg - q0), 0);
            chk("agree_len", n_dv - v0, 256);

            tick(0, 480, 0, 0, 0); tick(700, 10, 0, 1, 0);
            scan(1);
            set_rgb(600, 600, 600); tick(5, 5, 0, 0, 0); idle(1);
            chk("vga600", bus.VGA_Red, 600);

            tick(0, 480, 0, 0, 0); tick(700, 10, 0, 1, 0);
            scan(2);
            classify_z(32'sd5);
            bus.label = 0;
            q0 = n_neg;
            tick(700, 10, 0, 0, 1); idle(260);
            chk("pattern_neg_cnt", n_neg - q0, 86);

            tick(700, 10, 0, 0, 1);
            found = 0;
            for (int k = 0; k < 300 && !found; k++) begin
               idle(1);
               if (bus.delta_valid === 1'b1 && bus.delta_idx == 8'd100) found = 1;
            end
            chk("reach_idx100", found, 1);
            #2 RST = 1'b0;
            #1;
            chk("abort_valid", bus.delta_valid, 0);
            chk("abort_idx", bus.delta_idx, 0);
            chk("abort_hex", bus.To_Hex, 0);
            repeat (2) @(negedge Clk);
            RST = 1'b1;
            g0 = n_get;
            scan(0);
            chk("no_get_before_rsth", n_get - g0, 0);
            tick(0, 480, 0, 0, 0);
            g0 = n_get;
            scan(0);
            chk("resume_gets", n_get - g0, 256);
            idle(3);
         end
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/neural_classifier.md
NEURAL_CLASSIFIER -- requirements
Module: neural_classifier

Interface
REQ-001 SHALL have parameter N_IN, default 256, meaning number of perceptron inputs (16x16 grid).
REQ-002 SHALL have parameter LR, default 4, meaning signed 8-bit learning-rate step.
REQ-003 SHALL have parameter INK_TH, default 1536, meaning 12-bit brightness threshold for ink.
REQ-004 Clk  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 Draw_X, Draw_Y  in  10 each  current pixel coordinates; 0..639 and 0..479 active, other values blank.
REQ-007 oVGA_R, oVGA_G, oVGA_B  in  10 each  camera pixel colour.
REQ-008 label  in  1  training target class.
REQ-009 Z  in  32  signed weighted sum H·w.
REQ-010 classify, Record_X, Up_W  in  1 each  single-cycle command strobes.
REQ-011 VGA_Red, VGA_Green, VGA_Blue  out  10 each  display colour.
REQ-012 x_values  out  1  sampled binary input.
REQ-013 Get  out  1  x_values valid strobe.
REQ-014 Get_done  out  1  frame sample set complete.
REQ-015 RstH  out  1  clear-sum strobe.
REQ-016 Hw  out  1  class decision.
REQ-017 delta_w  out  8  signed weight delta.
REQ-018 delta_valid  out  1  delta_w valid.
REQ-019 delta_idx  out  8  input index of delta_w.
REQ-020 To_Hex  out  16  hex display value.

Function
REQ-021 Sample point: Draw_X<256, Draw_Y<256, Draw_X[3:0]==0, Draw_Y[3:0]==0; index = {Draw_Y[7:4],Draw_X[7:4]}.
REQ-022 At a sample point, SHALL register x_values = (R+G+B, 12-bit) < INK_TH and pulse Get one cycle later, for one cycle.
REQ-023 A 9-bit sample counter SHALL increment per Get; on reaching N_IN, Get_done SHALL pulse one cycle and further Get SHALL be suppressed until RstH.
REQ-024 RstH SHALL pulse one cycle when Draw_X==0 and Draw_Y==480; it clears the sample counter; RstH has priority over a same-cycle Get.
REQ-025 VGA outputs SHALL be registered (1-cycle latency): inside 256x256 window, 0 if pixel is ink, else input colour; pixels with Draw_X[3:0]==0 or Draw_Y[3:0]==0 in window SHALL be 10'h3FF grid; outside window, pass-through; blank coordinates give 0.
REQ-026 While Record_X was last strobed after RstH (record mode), each Get SHALL store x_values into bit index of a N_IN-bit register.
REQ-027 Up_W SHALL start a stream: N_IN consecutive cycles, delta_valid=1, delta_idx=0..N_IN-1, delta_w = x[i] ? (label ? +LR : -LR) : 0 when label!=Hw, else 0.
REQ-028 Up_W during an active stream SHALL be ignored; Record_X during stream SHALL not alter bits being streamed (stream uses snapshot).
REQ-029 classify SHALL register Hw = (signed Z > 0); Z==0 gives 0.
REQ-030 On classify, To_Hex[15:12]={3'b0,Hw}; To_Hex[11:0]=|Z| saturated to 12'hFFF (Z=-2^31 saturates).
REQ-031 Hw and To_Hex SHALL hold between classify strobes.

Reset
REQ-032 RST low SHALL asynchronously clear all registers: VGA outputs 0, x_values 0, Get 0, Get_done 0, RstH 0, Hw 0, delta_w 0, delta_valid 0, delta_idx 0, To_Hex 0, counters and x register 0, stream idle.
REQ-033 Reset mid-stream or mid-frame SHALL abort; operation resumes at next RstH.

Structure
REQ-034 N_IN, LR, INK_TH defaults, grid size 16 and window 256 SHALL live in shared package nn_pkg.
REQ-035 Delta generation (x register, snapshot, stream counter) SHALL be sub-module delta_w_gen; sampling, display and classifier logic stay in top.

Verification
REQ-036 RGB=210 each, scan full frame -> 256 Get pulses, x_values=1 each, one Get_done after 256th.
REQ-037 RGB=600 each (1800) -> x_values=0 all; VGA in window = 600 except grid 10'h3FF.
REQ-038 Z=32'sd5 + classify -> Hw=1, To_Hex=16'h1005; Z=-32'sd5000 -> Hw=0, To_Hex=16'h0FFF.
REQ-039 x all 1, label=1, Hw=0, Up_W -> 256 cycles delta_w=+4, idx 0..255; label=0 same Hw -> all 0.
REQ-040 RST low during stream at idx 100 -> delta_valid=0 immediately, idx=0.
